ast_string_collector: RTL and testbench



---
 rtl/bloom_filter_pkg.sv | 6 +
 rtl/sat_counter.sv | 18 +
 rtl/ast_string_collector.sv | 89 ++++++++
 tb/tb_ast_string_collector.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_filter_pkg.sv
// bloom_filter_pkg: shared defaults and collector state encoding
package bloom_filter_pkg;
  localparam int BYTE_W_DEF = 8;
  localparam int MAX_STR_SIZE_DEF = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_OUTPUT, ST_DROP} coll_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with a clear strobe that never loses a coincident event
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             inc_i,
  input  logic             clean_stb_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] r_cnt;
  // A clear on the same cycle as an event restarts the count at one
  always_ff @(posedge clk_i)
    if (srst_i) r_cnt <= '0;
    else if (clean_stb_i) r_cnt <= CNT_W'(inc_i);
    else if (inc_i && ~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
  assign cnt_o = r_cnt;
endmodule

// File: rtl/ast_string_collector.sv
// ast_string_collector: reassembles Avalon-ST packets into parallel length-tagged strings
module ast_string_collector
  import bloom_filter_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int AST_SINK_SYMBOLS = 8,
  parameter bit AST_SINK_ORDER = 1'b1,
  parameter int MAX_STR_SIZE = MAX_STR_SIZE_DEF,
  parameter int CNT_W = 32,
  parameter int AST_SINK_EMPTY_W = (AST_SINK_SYMBOLS == 1) ? 1 : $clog2(AST_SINK_SYMBOLS),
  parameter int LEN_W = $clog2(MAX_STR_SIZE) + 1
) (
  input  logic                                      clk_i,
  input  logic                                      srst_i,
  input  logic [AST_SINK_SYMBOLS-1:0][BYTE_W-1:0]   ast_sink_data_i,
  output logic                                      ast_sink_ready_o,
  input  logic                                      ast_sink_valid_i,
  input  logic [AST_SINK_EMPTY_W-1:0]               ast_sink_empty_i,
  input  logic                                      ast_sink_startofpacket_i,
  input  logic                                      ast_sink_endofpacket_i,
  output logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]       string_data_o,
  output logic [LEN_W-1:0]                          string_len_o,
  output logic                                      string_valid_o,
  input  logic                                      string_ready_i,
  output logic [CNT_W-1:0]                          err_framing_cnt_o,
  output logic [CNT_W-1:0]                          err_oversize_cnt_o,
  input  logic                                      err_cnt_clean_stb_i
);
  localparam int S = AST_SINK_SYMBOLS;
  localparam int SUM_W = $clog2(MAX_STR_SIZE + S + 1) + 1;
  coll_state_t r_state;
  logic r_valid;
  logic [MAX_STR_SIZE-1:0][BYTE_W-1:0] r_buf, w_buf;
  logic [LEN_W-1:0] r_len;
  logic [SUM_W-1:0] w_nb, w_base, w_end;
  logic w_ready, w_acc, w_coll, w_ovs, w_frm_inc, w_ovs_inc;
  // Beat decode: byte count, write offset, error events and the merged buffer image
  always_comb begin
    w_ready = (r_state != ST_OUTPUT) && !srst_i;
    w_acc = ast_sink_valid_i && w_ready;
    w_nb = !ast_sink_endofpacket_i ? SUM_W'(S)
         : (SUM_W'(ast_sink_empty_i) >= SUM_W'(S)) ? SUM_W'(1)
         : SUM_W'(S) - SUM_W'(ast_sink_empty_i);
    w_base = ast_sink_startofpacket_i ? '0 : SUM_W'(r_len);
    w_end = w_base + w_nb;
    w_coll = ast_sink_startofpacket_i || (r_state == ST_COLLECT);
    w_ovs = w_coll && (w_end > SUM_W'(MAX_STR_SIZE));
    w_frm_inc = w_acc && ((r_state == ST_IDLE) ? !ast_sink_startofpacket_i
                                               : (r_state == ST_COLLECT) && ast_sink_startofpacket_i);
    w_ovs_inc = w_acc && w_ovs;
    w_buf = ast_sink_startofpacket_i ? '0 : r_buf;
    for (int j = 0; j < MAX_STR_SIZE; j++)
      for (int k = 0; k < S; k++)
        if (SUM_W'(k) < w_nb && w_base + SUM_W'(k) == SUM_W'(j))
          w_buf[j] = AST_SINK_ORDER ? ast_sink_data_i[S-1-k] : ast_sink_data_i[k];
  end
  // Collector FSM: r_len doubles as the append offset until the string is presented
  always_ff @(posedge clk_i)
    if (srst_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_buf <= '0;
      r_len <= '0;
    end else if (r_state == ST_OUTPUT) begin
      if (string_ready_i) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
      end
    end else if (w_acc) begin
      if (w_coll && !w_ovs) begin
        r_buf <= w_buf;
        r_len <= w_end[LEN_W-1:0];
        r_state <= ast_sink_endofpacket_i ? ST_OUTPUT : ST_COLLECT;
        r_valid <= ast_sink_endofpacket_i;
      end else r_state <= ast_sink_endofpacket_i ? ST_IDLE : ST_DROP;
    end
  assign ast_sink_ready_o = w_ready;
  assign string_data_o = r_buf;
  assign string_len_o = r_len;
  assign string_valid_o = r_valid;
  sat_counter #(.CNT_W(CNT_W)) u_frm (
    .clk_i(clk_i), .srst_i(srst_i), .inc_i(w_frm_inc),
    .clean_stb_i(err_cnt_clean_stb_i), .cnt_o(err_framing_cnt_o)
  );
  sat_counter #(.CNT_W(CNT_W)) u_ovs (
    .clk_i(clk_i), .srst_i(srst_i), .inc_i(w_ovs_inc),
    .clean_stb_i(err_cnt_clean_stb_i), .cnt_o(err_oversize_cnt_o)
  );
endmodule

// File: tb/tb_ast_string_collector.sv
// tb_ast_string_collector: directed stimulus with a queued scoreboard and decoupled output monitor
module tb_ast_string_collector;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic srst = 1'b1;
  logic [7:0][7:0] a_data = '0;
  logic a_ready, a_valid = 1'b0, a_sop = 1'b0, a_eop = 1'b0, a_sready = 1'b1, a_clean = 1'b0;
  logic [2:0] a_empty = '0;
  logic [15:0][7:0] a_sdata;
  logic [4:0] a_len;
  logic a_svalid;
  logic [2:0] a_frm, a_ovs;
  logic [0:0][7:0] b_data = '0;
  logic b_ready, b_valid = 1'b0, b_sop = 1'b0, b_eop = 1'b0, b_sready = 1'b1, b_clean = 1'b0;
  logic [0:0] b_empty = '0;
  logic [3:0][7:0] b_sdata;
  logic [2:0] b_len;
  logic b_svalid;
  logic [3:0] b_frm, b_ovs;
  ast_string_collector #(
    .BYTE_W(8), .AST_SINK_SYMBOLS(8), .AST_SINK_ORDER(1'b1), .MAX_STR_SIZE(16), .CNT_W(3)
  ) u_a (
    .clk_i(clk), .srst_i(srst), .ast_sink_data_i(a_data), .ast_sink_ready_o(a_ready),
    .ast_sink_valid_i(a_valid), .ast_sink_empty_i(a_empty), .ast_sink_startofpacket_i(a_sop),
    .ast_sink_endofpacket_i(a_eop), .string_data_o(a_sdata), .string_len_o(a_len),
    .string_valid_o(a_svalid), .string_ready_i(a_sready), .err_framing_cnt_o(a_frm),
    .err_oversize_cnt_o(a_ovs), .err_cnt_clean_stb_i(a_clean)
  );
  ast_string_collector #(
    .BYTE_W(8), .AST_SINK_SYMBOLS(1), .AST_SINK_ORDER(1'b0), .MAX_STR_SIZE(4), .CNT_W(4)
  ) u_b (
    .clk_i(clk), .srst_i(srst), .ast_sink_data_i(b_data), .ast_sink_ready_o(b_ready),
    .ast_sink_valid_i(b_valid), .ast_sink_empty_i(b_empty), .ast_sink_startofpacket_i(b_sop),
    .ast_sink_endofpacket_i(b_eop), .string_data_o(b_sdata), .string_len_o(b_len),
    .string_valid_o(b_svalid), .string_ready_i(b_sready), .err_framing_cnt_o(b_frm),
    .err_oversize_cnt_o(b_ovs), .err_cnt_clean_stb_i(b_clean)
  );
  typedef struct packed {
    logic [15:0][7:0] d;
    logic [4:0] len;
  } exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb, ez;
  int n_chk = 0, n_pass = 0;
  function automatic exp_t mk(input logic [127:0] s, input int len);
    exp_t e;
    e.d = '0;
    e.len = 5'(len);
    for (int i = 0; i < len; i++) e.d[i] = s[8*(len-1-i) +: 8];
    return e;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask
  task automatic send_a(input logic [63:0] d, input logic sop, input logic eop, input logic [2:0] emp);
    int n = 0;
    logic acc = 1'b0;
    a_data = d; a_sop = sop; a_eop = eop; a_empty = emp; a_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = a_ready;
      @(posedge clk);
      #1;
      n++;
    end
    a_valid = 1'b0;
    if (!acc) chk("a_beat_timeout", {127'd0, acc}, 1);
  endtask
  task automatic send_b(input logic [7:0] d, input logic sop, input logic eop);
    int n = 0;
    logic acc = 1'b0;
    b_data = d; b_sop = sop; b_eop = eop; b_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = b_ready;
      @(posedge clk);
      #1;
      n++;
    end
    b_valid = 1'b0;
    if (!acc) chk("b_beat_timeout", {127'd0, acc}, 1);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (a_svalid && a_sready) begin
          if (qa.size() == 0) chk("a_unexpected_string_len", a_len, 0);
          else begin
            ea = qa.pop_front();
            chk("a_string_data", a_sdata, ea.d);
            chk("a_string_len", a_len, ea.len);
          end
        end
        if (b_svalid && b_sready) begin
          if (qb.size() == 0) chk("b_unexpected_string_len", b_len, 0);
          else begin
            eb = qb.pop_front();
            chk("b_string_data", b_sdata, eb.d);
            chk("b_string_len", b_len, eb.len);
          end
        end
      end
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_valid", a_svalid, 0);
    chk("rst_a_data", a_sdata, 0);
    chk("rst_a_len", a_len, 0);
    chk("rst_a_frm", a_frm, 0);
    chk("rst_a_ovs", a_ovs, 0);
    step();
    srst = 1'b0;
    @(negedge clk);
    chk("rst_a_ready_after", a_ready, 1);
    step();
    qa.push_back(mk("ABCDEFGHIJK", 11));
    send_a("ABCDEFGH", 1, 0, 0);
    chk("t1_valid_mid", a_svalid, 0);
    send_a("IJKxxxxx", 0, 1, 5);
    chk("t1_valid_after_eop", a_svalid, 1);
    chk("t1_ready_in_output", a_ready, 0);
    step();
    chk("t1_ready_after_hs", a_ready, 1);
    a_sready = 1'b0;
    ez = mk("Z", 1);
    qa.push_back(ez);
    send_a("Zqqqqqqq", 1, 1, 7);
    repeat (5) begin
      @(negedge clk);
      chk("t2_valid_held", a_svalid, 1);
      chk("t2_ready_low", a_ready, 0);
      chk("t2_data_held", a_sdata, ez.d);
      chk("t2_len_held", a_len, 1);
    end
    step();
    a_sready = 1'b1;
    step();
    chk("t2_ready_after_hs", a_ready, 1);
    chk("t2_valid_after_hs", a_svalid, 0);
    send_a("00000000", 1, 0, 0);
    send_a("11111111", 0, 0, 0);
    send_a("22222222", 0, 1, 0);
    chk("t3_ovs_cnt", a_ovs, 1);
    chk("t3_no_string", a_svalid, 0);
    qa.push_back(mk("WXYZ", 4));
    send_a("WXYZ----", 1, 1, 4);
    chk("t3_next_valid", a_svalid, 1);
    step();
    qa.push_back(mk("0123456789abcdef", 16));
    send_a("01234567", 1, 0, 0);
    send_a("89abcdef", 0, 1, 0);
    step();
    chk("t3_full_no_ovs", a_ovs, 1);
    send_a("11111111", 0, 0, 0);
    chk("t4_frm_idle", a_frm, 1);
    send_a("PPPPPPPP", 1, 0, 0);
    chk("t4_frm_drop_sop", a_frm, 1);
    qa.push_back(mk("QRSTUVWXabc", 11));
    send_a("QRSTUVWX", 1, 0, 0);
    send_a("abcxxxxx", 0, 1, 5);
    chk("t4_frm_collect_sop", a_frm, 2);
    step();
    a_clean = 1'b1;
    step();
    a_clean = 1'b0;
    chk("t5_clean_frm", a_frm, 0);
    chk("t5_clean_ovs", a_ovs, 0);
    repeat (8) send_a("eeeeeeee", 0, 1, 0);
    chk("t5_frm_sat", a_frm, 7);
    repeat (8) begin
      send_a("00000000", 1, 0, 0);
      send_a("11111111", 0, 0, 0);
      send_a("22222222", 0, 1, 0);
    end
    chk("t5_ovs_sat", a_ovs, 7);
    chk("t5_frm_sat_hold", a_frm, 7);
    a_clean = 1'b1;
    send_a("eeeeeeee", 0, 1, 0);
    a_clean = 1'b0;
    chk("t5_clean_with_event", a_frm, 1);
    chk("t5_clean_no_event", a_ovs, 0);
    qb.push_back(mk("abcd", 4));
    send_b("a", 1, 0);
    send_b("b", 0, 0);
    send_b("c", 0, 0);
    send_b("d", 0, 1);
    chk("t6_b_valid", b_svalid, 1);
    chk("t6_b_len", b_len, 4);
    step();
    send_b("e", 1, 0);
    send_b("f", 0, 0);
    srst = 1'b1;
    step();
    @(negedge clk);
    chk("t6_rst_b_valid", b_svalid, 0);
    chk("t6_rst_b_data", b_sdata, 0);
    chk("t6_rst_b_len", b_len, 0);
    chk("t6_rst_b_ready", b_ready, 0);
    chk("t6_rst_b_frm", b_frm, 0);
    chk("t6_rst_b_ovs", b_ovs, 0);
    chk("t6_rst_a_frm", a_frm, 0);
    step();
    srst = 1'b0;
    @(negedge clk);
    chk("t6_b_ready_after", b_ready, 1);
    step();
    qb.push_back(mk("h", 1));
    send_b("h", 1, 1);
    step();
    step();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
